// File: rtl/glyph_pkg.sv
// Shared constants and types for the glyph ROM reader.
//   WIDTH         : bits per ROM word (pixels per glyph row)
//   ROM_ADDR_BITS : glyph ROM address width
//   ROW_BITS      : row-index bits; the glyph index takes the remaining address bits
package glyph_pkg;

  localparam int unsigned WIDTH         = 64;
  localparam int unsigned ROM_ADDR_BITS = 13;
  localparam int unsigned ROW_BITS      = 6;
  localparam int unsigned GLYPH_BITS    = ROM_ADDR_BITS - ROW_BITS;
  localparam int unsigned CNT_BITS      = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StShift
  } state_e;

endpackage

// File: rtl/glyph_serializer.sv
// Row shift register for the glyph reader.
// Loads a full ROM word and emits it one bit per shift, either MSB-first or
// (mirror_i high) LSB-first. Tracks the pixel index so the last pixel can be flagged.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture data_i and restart the pixel count
//   shift_i    : advance one pixel (ignored while load_i is high)
//   mirror_i   : select LSB-first emission
//   data_i     : ROM word
//   bit_o      : current pixel
//   last_o     : current pixel is the final one of the row
module glyph_serializer
  import glyph_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             mirror_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o,
  output logic             last_o
);

  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sreg_d = data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      sreg_d = mirror_i ? (sreg_q >> 1) : (sreg_q << 1);
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bit_o  = mirror_i ? sreg_q[0] : sreg_q[WIDTH-1];
  assign last_o = (cnt_q == CNT_BITS'(WIDTH - 1));

endmodule

// File: rtl/glyph_row_reader.sv
// Glyph ROM reader: accepts a (glyph, row) request, addresses the registered-read
// glyph ROM, captures the row word and streams it out one pixel per handshake.
// Optional build macro GLYPH_MIRROR_EN adds req_mirror (latched on accept) which
// streams the row LSB-first for left-facing sprites.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake; req_glyph/req_row held by requester
//   rom_addr/rom_data    : ROM address (registered) and read data (one-cycle latency)
//   pix_valid/pix_ready  : pixel handshake; pix_out is the pixel, pix_last marks pixel WIDTH-1
//   busy                 : a request is in flight
module glyph_row_reader
  import glyph_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [GLYPH_BITS-1:0]    req_glyph,
  input  logic [ROW_BITS-1:0]      req_row,
`ifdef GLYPH_MIRROR_EN
  input  logic                     req_mirror,
`endif
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [WIDTH-1:0]         rom_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_out,
  output logic                     pix_last,
  output logic                     busy
);

  state_e                   state_q, state_d;
  logic [ROM_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     accept;
  logic                     in_shift;
  logic                     ser_load, ser_shift, ser_mirror, ser_bit, ser_last;

  assign in_shift = (state_q == StShift);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    pix_valid = 1'b0;
    // Ready on the last-pixel transfer so back-to-back rows skip the idle cycle.
    req_ready = (state_q == StIdle) | (in_shift & ser_last & pix_ready);
    accept    = req_valid & req_ready;

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      // ROM samples rom_addr on this edge.
      StIssue: state_d = StWait;
      // ROM data is valid now; capture it.
      StWait: begin
        ser_load = 1'b1;
        state_d  = StShift;
      end
      StShift: begin
        pix_valid = 1'b1;
        if (pix_ready) begin
          ser_shift = 1'b1;
          if (ser_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StIssue;
      addr_d  = {req_glyph, req_row};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef GLYPH_MIRROR_EN
  logic mirror_q, mirror_d;

  always_comb begin
    mirror_d = mirror_q;
    if (accept) mirror_d = req_mirror;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mirror_q <= 1'b0;
    else        mirror_q <= mirror_d;
  end

  assign ser_mirror = mirror_q;
`else
  assign ser_mirror = 1'b0;
`endif

  glyph_serializer u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ser_load),
    .shift_i  (ser_shift),
    .mirror_i (ser_mirror),
    .data_i   (rom_data),
    .bit_o    (ser_bit),
    .last_o   (ser_last)
  );

  assign rom_addr = addr_q;
  assign pix_out  = in_shift & ser_bit;
  assign pix_last = in_shift & ser_last;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_glyph_row_reader.sv
// Scoreboard bench for glyph_row_reader: accepted requests push the expected
// pixel stream (read from a ROM array) into a queue; a monitor pops on every
// pixel transfer. Also covers address, latency, hold under back-pressure and reset.
module tb_glyph_row_reader;
  import glyph_pkg::*;

`ifdef GLYPH_MIRROR_EN
  localparam bit MirrorEn = 1'b1;
`else
  localparam bit MirrorEn = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     req_valid;
  logic                     req_ready;
  logic [GLYPH_BITS-1:0]    req_glyph;
  logic [ROW_BITS-1:0]      req_row;
  logic                     req_mirror;
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic [WIDTH-1:0]         rom_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     pix_out;
  logic                     pix_last;
  logic                     busy;

  always #5 clk = ~clk;

  glyph_row_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_glyph (req_glyph),
    .req_row   (req_row),
`ifdef GLYPH_MIRROR_EN
    .req_mirror(req_mirror),
`endif
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_out   (pix_out),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  // Glyph ROM with a one-cycle registered read.
  logic [WIDTH-1:0] rom_mem [0:(1<<ROM_ADDR_BITS)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct packed {
    logic pix;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfer_cnt = 0;
  int   acc_cnt = 0;
  int   issued = 0;
  int   pix_mode = 0;
  int   pr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Consumer back-pressure: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  always @(posedge clk) begin
    #1;
    pr_cnt++;
    case (pix_mode)
      1:       pix_ready = (pr_cnt % 3 == 0);
      2:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b1;
    endcase
  end

  // Monitor / scoreboard, sampled on the falling edge.
  int                       lat_k = 0;
  bit                       addr_pend = 0;
  logic [ROM_ADDR_BITS-1:0] exp_addr;
  bit                       prev_stall = 0;
  logic                     prev_out, prev_last;
  exp_t                     e;
  logic [WIDTH-1:0]         w;
  bit                       m;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      lat_k      = 0;
      addr_pend  = 0;
      prev_stall = 0;
    end else begin
      if (addr_pend) begin
        check("rom_addr", rom_addr, exp_addr);
        addr_pend = 0;
      end
      if (lat_k != 0) begin
        check("latency_pix_valid", pix_valid, lat_k == 3);
        lat_k = (lat_k == 3) ? 0 : lat_k + 1;
      end
      if (prev_stall) begin
        check("hold_valid", pix_valid, 1'b1);
        check("hold_out", pix_out, prev_out);
        check("hold_last", pix_last, prev_last);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_pixel: got pixel %0b with nothing expected at %0t", pix_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("pix_out", pix_out, e.pix);
          check("pix_last", pix_last, e.last);
        end
        xfer_cnt++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_out   = pix_out;
      prev_last  = pix_last;
      if (req_valid && req_ready) begin
        w = rom_mem[{req_glyph, req_row}];
        m = MirrorEn && req_mirror;
        for (int i = 0; i < WIDTH; i++) begin
          e.pix  = m ? w[i] : w[WIDTH-1-i];
          e.last = (i == WIDTH - 1);
          exp_q.push_back(e);
        end
        exp_addr  = {req_glyph, req_row};
        addr_pend = 1;
        lat_k     = 1;
        acc_cnt++;
      end
    end
  end

  // Present a request and hold it until accepted; returns just after the accept edge.
  task automatic do_req(input logic [GLYPH_BITS-1:0] g, input logic [ROW_BITS-1:0] r,
                        input logic mir);
    bit ok = 0;
    req_valid  = 1'b1;
    req_glyph  = g;
    req_row    = r;
    req_mirror = mir;
    issued++;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got no accept expected accept within 2000 cycles");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_glyph  = '0;
    req_row    = '0;
    req_mirror = 1'b0;
    pix_ready  = 1'b1;
    for (int a = 0; a < (1 << ROM_ADDR_BITS); a++) rom_mem[a] = {$urandom, $urandom};
    rom_mem[13'h143]  = 64'h8000_0000_0000_0001;
    rom_mem[13'h1FFF] = 64'hFFFF_FFFF_FFFF_FFFF;
    rom_mem[13'h0A5]  = 64'hF000_0000_0000_0000;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    check("reset_pix_valid", pix_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_pix_out", pix_out, 1'b0);
    check("reset_pix_last", pix_last, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single row, always ready.
    pix_mode = 0;
    base = xfer_cnt;
    do_req(7'd5, 6'd3, 1'b0);
    wait_drain();
    check("single_row_transfers", xfer_cnt - base, WIDTH);

    // Same row under back-pressure.
    pix_mode = 1;
    base = xfer_cnt;
    do_req(7'd5, 6'd3, 1'b0);
    wait_drain();
    check("backpressure_transfers", xfer_cnt - base, WIDTH);

    // Back-to-back: second request held during the first row.
    pix_mode = 0;
    base = xfer_cnt;
    do_req(7'd5, 6'd3, 1'b0);
    do_req(7'd127, 6'd63, 1'b0);
    wait_drain();
    check("b2b_transfers", xfer_cnt - base, 2 * WIDTH);

    // Reset mid-row after 10 pixels.
    base = xfer_cnt;
    do_req(7'd5, 6'd3, 1'b0);
    for (int i = 0; i < 200 && xfer_cnt < base + 10; i++) begin
      @(posedge clk);
      #1;
    end
    check("midrow_pixels_before_reset", xfer_cnt - base, 10);
    rst_n = 1'b0;
    #1;
    check("midrow_reset_pix_valid", pix_valid, 1'b0);
    check("midrow_reset_busy", busy, 1'b0);
    check("midrow_reset_req_ready", req_ready, 1'b1);
    check("midrow_reset_rom_addr", rom_addr, 0);
    check("midrow_reset_pix_last", pix_last, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = xfer_cnt;
    do_req(7'd127, 6'd63, 1'b0);
    wait_drain();
    check("post_reset_transfers", xfer_cnt - base, WIDTH);

`ifdef GLYPH_MIRROR_EN
    // Mirrored and normal emission of 0xF000...
    do_req(7'd2, 6'd37, 1'b1);
    wait_drain();
    do_req(7'd2, 6'd37, 1'b0);
    wait_drain();
`endif

    // Random requests, random back-pressure, issued back-to-back.
    pix_mode = 2;
    for (int n = 0; n < 12; n++) begin
      do_req(GLYPH_BITS'($urandom), ROW_BITS'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_drain();

    check("accept_count", acc_cnt, issued);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
